fp_add_scheduler: RTL and testbench
===================================

# fp_add_scheduler

Shares one fixed-latency pipelined single-precision FP adder among `NUM_REQ` requesters. Grants one requester per cycle by round-robin, registers its operands into the adder, carries the requester ID down a tag pipeline matched to the adder latency, and routes each result back to its originator. It sits between the requester clients and the adder. It also provides a hold/drain control so software can quiesce the adder.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `LAT`, default 5: adder latency in cycles, from operand-valid to result-valid, ≥1.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low.
- `req_valid`, in, NUM_REQ: requester i presents an operation.
- `req_ready`, out, NUM_REQ: one-hot grant. A handshake on i occurs when `req_valid[i] & req_ready[i]`.
- `req_a`, in, NUM_REQ*32: operand A per requester, IEEE-754 SP, slice i at [32i+31:32i].
- `req_b`, in, NUM_REQ*32: operand B per requester, same packing.
- `hold`, in, 1: when high, no new grants are issued.
- `adder_valid_o`, out, 1: operands to adder are valid.
- `adder_a_o`, out, 32: operand A to adder.
- `adder_b_o`, out, 32: operand B to adder.
- `adder_res_i`, in, 32: adder result, valid exactly `LAT` cycles after the matching `adder_valid_o`.
- `rsp_valid`, out, NUM_REQ: one-hot result strobe. There is no backpressure; the requester must accept it.
- `rsp_data`, out, 32: result, broadcast to all requesters.
- `inflight`, out, clog2(LAT+3): number of issued operations not yet returned.
- `drained`, out, 1: high when in DRAIN state and `inflight`==0.

## Operation
- **Arbitration**: round-robin over the requesters whose `req_valid` is high, starting the search at pointer `ptr`.
  - `req_ready` is combinational from `req_valid`, `ptr`, `hold` and the state.
  - At most one bit of `req_ready` is high. `req_ready` is never high for a requester whose `req_valid` is low.
- **Pointer update**: after a grant to i, `ptr` becomes (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no grant, `ptr` is unchanged.
- **Issue**: on a handshake, `adder_a_o`/`adder_b_o` register the granted operands and `adder_valid_o` goes high for one cycle. Without a handshake, `adder_valid_o`=0 and the operand outputs hold their last value.
- **Tag pipe**: LAT entries of {valid, id}. Entry 0 is loaded with {adder_valid_o, granted id}. Entries shift every cycle with no stall.
- **Response**: when tag LAT-1 is valid, `rsp_data` registers `adder_res_i` and `rsp_valid[id]`=1 for one cycle. Otherwise `rsp_valid`=0 and `rsp_data` holds its last value.
- **In-flight counter**:
  - Increments on handshake and decrements on response.
  - Both in the same cycle: unchanged.
  - Never exceeds LAT+2 and never underflows.
- **States**:
  - RUN: grants allowed while `hold`=0.
  - `hold`=1 in RUN → DRAIN. `hold` is also gated combinationally, so there is no grant in the cycle `hold` rises.
  - DRAIN: no grants; responses still complete.
  - DRAIN with `hold`=0 → RUN, regardless of `inflight`.
- Operands are passed through unmodified. The scheduler does no FP interpretation.

## Timing
- Handshake at edge k → `adder_valid_o` high during cycle k+1 → `adder_res_i` sampled at edge k+1+LAT → `rsp_valid` high during cycle k+2+LAT.
- Fixed request-to-response latency is LAT+2 edges. Responses return in issue order.
- Sustained throughput is one operation per cycle.
- Reset (asynchronous, any time):
  - `req_ready`=0, `adder_valid_o`=0, `adder_a_o`=0, `adder_b_o`=0.
  - `rsp_valid`=0, `rsp_data`=0, `inflight`=0, `drained`=0.
  - `ptr`=0, all tags cleared, state RUN.
- Reset mid-operation: in-flight operations are discarded and produce no response.
- `drained` is registered. It rises in the cycle after the last response of a drain.

## Structure
- Package `fp_add_pkg`: `FP_W`=32; the tag struct {valid, id}; the state enum {RUN, DRAIN}; helper functions for id width and count width.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational. `ptr` lives in the parent.

## Test plan
- Single request, NUM_REQ=4, LAT=5: req0 with 1.5 (0x3FC00000) + 2.25 (0x40100000). Required: `adder_valid_o` at cycle 1; with the adder model returning 0x40700000, `rsp_valid`=4'b0001 at cycle 7; `inflight` goes 0→1→0.
- All four requesting continuously from reset: grants 0,1,2,3,0,… one per cycle. Responses appear in the same order starting 7 cycles later. `inflight` saturates at 7.
- Requesters 1 and 3 only, `ptr`=2: grants 3 then 1 then 3; wrap-around is verified.
- Drain: `hold` asserted in the same cycle as req2 is valid. Required: no grant that cycle; the 3 prior in-flight operations return; `drained`=1 one cycle after the last `rsp_valid`. Deasserting `hold` grants req2 the next cycle.
- Reset asserted with 4 operations in flight: all outputs go to 0 immediately. After release, no stale `rsp_valid` appears within LAT+2 cycles.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and sizing helpers for the FP adder scheduler.
// Tag ids are sized for the largest supported requester count (8).
package fp_add_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned lat);
        return $clog2(lat + 3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// The pointer register is owned by the parent.
module rr_arbiter
    import fp_add_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [id_w(N)-1:0] ptr,
    input  logic               en,
    output logic [N-1:0]       gnt,
    output logic [id_w(N)-1:0] gnt_id
);

    localparam int unsigned IDW = id_w(N);

    int unsigned    idx;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) idx = idx - N;
            sel = IDW'(idx);
            if (en && !found && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_id   = sel;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency pipelined FP adder among NUM_REQ requesters,
// tagging each issue with its requester id and routing results back in order.
module fp_add_scheduler
    import fp_add_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAT     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic                    hold,
    output logic                    adder_valid_o,
    output logic [FP_W-1:0]         adder_a_o,
    output logic [FP_W-1:0]         adder_b_o,
    input  logic [FP_W-1:0]         adder_res_i,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic [cnt_w(LAT)-1:0]   inflight,
    output logic                    drained
);

    localparam int unsigned    IDW      = id_w(NUM_REQ);
    localparam int unsigned    CW       = cnt_w(LAT);
    localparam logic [CW-1:0]  INFL_MAX = CW'(LAT + 2);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic               grant_en;
    logic               hs;
    logic               rsp_any;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     issue_id_q;
    tag_t               tags_q [LAT];
    logic [NUM_REQ-1:0] rsp_d;
    logic [CW-1:0]      inflight_d;

    // Reset also masks grants so req_ready is low while reset is held.
    assign grant_en = reset && (state_q == RUN) && !hold;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (grant_en),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    assign hs      = |req_ready;
    assign rsp_any = |rsp_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (hold)  state_d = DRAIN;
            DRAIN: if (!hold) state_d = RUN;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
    end

    always_comb begin
        rsp_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_d[i] = tags_q[LAT-1].valid && (tags_q[LAT-1].id == ID_MAX_W'(i));
        end
    end

    // An operation stays counted through the cycle its response is presented.
    always_comb begin
        inflight_d = inflight;
        if (hs && !rsp_any && inflight != INFL_MAX)
            inflight_d = inflight + 1'b1;
        else if (!hs && rsp_any && inflight != '0)
            inflight_d = inflight - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            adder_valid_o <= 1'b0;
            adder_a_o     <= '0;
            adder_b_o     <= '0;
            issue_id_q    <= '0;
            for (int unsigned i = 0; i < LAT; i++) tags_q[i] <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            inflight      <= '0;
            drained       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            adder_valid_o <= hs;
            if (hs) begin
                adder_a_o  <= req_a[FP_W*gnt_id +: FP_W];
                adder_b_o  <= req_b[FP_W*gnt_id +: FP_W];
                issue_id_q <= gnt_id;
            end
            tags_q[0] <= '{valid: adder_valid_o, id: ID_MAX_W'(issue_id_q)};
            for (int unsigned i = 1; i < LAT; i++) tags_q[i] <= tags_q[i-1];
            rsp_valid <= rsp_d;
            if (tags_q[LAT-1].valid) rsp_data <= adder_res_i;
            inflight  <= inflight_d;
            drained   <= (state_d == DRAIN) && (inflight_d == '0);
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized self-checking bench for fp_add_scheduler with a transaction-level
// scoreboard and a stand-in fixed-latency adder.
module tb_fp_add_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 5;
    localparam int unsigned CW      = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                 hold;
    logic                 adder_valid_o;
    logic [31:0]          adder_a_o;
    logic [31:0]          adder_b_o;
    logic [31:0]          adder_res_i;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [31:0]          rsp_data;
    logic [CW-1:0]        inflight;
    logic                 drained;

    always #5 clk = ~clk;

    fp_add_scheduler #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .hold          (hold),
        .adder_valid_o (adder_valid_o),
        .adder_a_o     (adder_a_o),
        .adder_b_o     (adder_b_o),
        .adder_res_i   (adder_res_i),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .inflight      (inflight),
        .drained       (drained)
    );

    // Any deterministic function of the operands exercises the routing.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    logic [31:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= adder_valid_o ? fake_add(adder_a_o, adder_b_o) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign adder_res_i = add_pipe[LAT-1];

    typedef struct {
        int unsigned id;
        logic [31:0] res;
        int unsigned due;
    } op_t;

    op_t         sb[$];
    int unsigned m_ptr;
    bit          m_drain;
    int unsigned edge_n;
    logic        exp_av;
    logic [31:0] exp_a, exp_b, exp_rd;
    logic [3:0]  exp_rv;
    int unsigned m_infl;
    logic        exp_drained;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] v, input bit h);
        int unsigned idx;
        if (h || m_drain) return 4'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (m_ptr + off) % NUM_REQ;
            if (v[idx]) return 4'(1 << idx);
        end
        return 4'b0;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_ptr = 0; m_drain = 0;
        exp_av = 0; exp_a = '0; exp_b = '0; exp_rd = '0; exp_rv = '0;
        m_infl = 0; exp_drained = 0;
    endtask

    task automatic check_outputs(input logic [3:0] g);
        check_eq("req_ready", 32'(req_ready), 32'(g));
        check_eq("adder_valid", 32'(adder_valid_o), 32'(exp_av));
        check_eq("adder_a", adder_a_o, exp_a);
        check_eq("adder_b", adder_b_o, exp_b);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check_eq("rsp_data", rsp_data, exp_rd);
        check_eq("inflight", 32'(inflight), m_infl);
        check_eq("drained", 32'(drained), 32'(exp_drained));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] v, input bit h, input bit rand_ops);
        logic [3:0]  g;
        int unsigned id;
        op_t         op;
        req_valid = v;
        hold      = h;
        if (rand_ops)
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = $urandom;
            end
        #1;
        g = model_grant(v, h);
        check_outputs(g);
        @(posedge clk);
        edge_n++;
        exp_av = (g != 0);
        if (g != 0) begin
            id = 0;
            for (int unsigned i = 0; i < NUM_REQ; i++) if (g[i]) id = i;
            exp_a  = req_a[id*32 +: 32];
            exp_b  = req_b[id*32 +: 32];
            op.id  = id;
            op.res = fake_add(exp_a, exp_b);
            op.due = edge_n + LAT + 1;
            sb.push_back(op);
            m_ptr = (id + 1) % NUM_REQ;
        end
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            exp_rv = 4'(1 << sb[0].id);
            exp_rd = sb[0].res;
            void'(sb.pop_front());
        end
        m_drain     = h;
        m_infl      = sb.size() + ((exp_rv != 0) ? 1 : 0);
        exp_drained = m_drain && (m_infl == 0);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_adder_valid", 32'(adder_valid_o), 32'd0);
        check_eq("rst_adder_a", adder_a_o, 32'd0);
        check_eq("rst_adder_b", adder_b_o, 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_inflight", 32'(inflight), 32'd0);
        check_eq("rst_drained", 32'(drained), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = '1; hold = 1'b0; req_a = '0; req_b = '0;
        edge_n = 0;
        model_clear();
        check_reset_state();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // single request: 1.5 + 2.25 from requester 0
        req_a[31:0] = 32'h3FC0_0000;
        req_b[31:0] = 32'h4010_0000;
        step(4'b0001, 0, 0);
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 0);

        // all four requesting continuously
        for (int i = 0; i < 20; i++) step(4'b1111, 0, 1);
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 1);

        // requesters 1 and 3 with pointer moved to 2 by a lone grant to 1
        step(4'b0010, 0, 1);
        for (int i = 0; i < 5; i++) step(4'b1010, 0, 1);
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 1);

        // drain with req2 pending when hold rises
        for (int i = 0; i < 3; i++) step(4'b0011, 0, 1);
        for (int i = 0; i < LAT + 5; i++) step(4'b0100, 1, 0);
        step(4'b0100, 0, 0);
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 0);

        // random traffic with occasional hold
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 1);

        // asynchronous reset with four operations in flight
        for (int i = 0; i < 4; i++) step(4'b1111, 0, 1);
        req_valid = 4'b1111;
        #2;
        reset = 1'b0;
        model_clear();
        check_reset_state();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 1);
        for (int i = 0; i < 10; i++) step(4'b1111, 0, 1);
        for (int i = 0; i < LAT + 3; i++) step(4'b0000, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
